// File: rtl/maf_mul_sequencer.sv
// maf_mul_sequencer: iterative radix-4 multiply-add, PP_PER_PASS partial products per cycle
module maf_mul_sequencer #(
    parameter int WIDTH       = 32,
    parameter int PP_PER_PASS = 4
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic [WIDTH-1:0]                                  in_a,
    input  logic [WIDTH-1:0]                                  in_b,
    input  logic [2*WIDTH-1:0]                                in_c,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [2*WIDTH-1:0]                                out_p,
    output logic                                              busy,
    output logic [$clog2(WIDTH/(2*PP_PER_PASS)+1)-1:0]        pass_cnt
);
    localparam int NPASS = WIDTH / (2 * PP_PER_PASS);
    localparam int CW    = $clog2(NPASS + 1);
    localparam int W2    = 2 * WIDTH;
    localparam int STEP  = 2 * PP_PER_PASS;

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    state_t            state, state_nxt;
    logic [W2-1:0]     a_sh, a3_sh, acc_s, acc_c, nxt_s, nxt_c, pp, t;
    logic [WIDTH-1:0]  b_sh;
    logic [1:0]        d;
    logic              last;

    assign last = pass_cnt == CW'(NPASS - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = (state == IDLE && in_valid)    ? ACCUM   :
                    (state == ACCUM && last)       ? RESOLVE :
                    (state == RESOLVE)             ? DONE    :
                    (state == DONE && out_ready)   ? IDLE    : state;
        in_ready  = state == IDLE;
        busy      = state != IDLE;
        out_valid = state == DONE;
    end

    // a_sh/a3_sh carry A and 3A pre-aligned to the current pass; b_sh exposes its digits at the bottom
    always_comb begin
        nxt_s = acc_s;
        nxt_c = acc_c;
        d     = '0;
        pp    = '0;
        t     = '0;
        for (int j = 0; j < PP_PER_PASS; j++) begin
            d     = b_sh[2*j +: 2];
            pp    = (d == 2'd0 ? '0 : d == 2'd1 ? a_sh : d == 2'd2 ? a_sh << 1 : a3_sh) << (2 * j);
            t     = nxt_s ^ nxt_c ^ pp;
            nxt_c = ((nxt_s & nxt_c) | (nxt_s & pp) | (nxt_c & pp)) << 1;
            nxt_s = t;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a_sh     <= '0;
            a3_sh    <= '0;
            b_sh     <= '0;
            acc_s    <= '0;
            acc_c    <= '0;
            out_p    <= '0;
            pass_cnt <= '0;
        end else if (state == IDLE && in_valid) begin
            a_sh     <= W2'(in_a);
            a3_sh    <= W2'(in_a) + (W2'(in_a) << 1);
            b_sh     <= in_b;
            acc_s    <= in_c;
            acc_c    <= '0;
            pass_cnt <= '0;
        end else if (state == ACCUM) begin
            a_sh     <= a_sh << STEP;
            a3_sh    <= a3_sh << STEP;
            b_sh     <= b_sh >> STEP;
            acc_s    <= nxt_s;
            acc_c    <= nxt_c;
            pass_cnt <= pass_cnt + 1'b1;
        end else if (state == RESOLVE) begin
            out_p    <= acc_s + acc_c;
        end
endmodule

// File: tb/tb_maf_mul_sequencer.sv
// tb_maf_mul_sequencer: directed vector table plus backpressure, mid-op reset and random runs
module tb_maf_mul_sequencer;
    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, in_ready, out_valid, out_ready = 0, busy;
    logic [31:0] in_a = 0, in_b = 0;
    logic [63:0] in_c = 0, out_p;
    logic [2:0]  pass_cnt;
    int          total = 0, bad = 0;

    maf_mul_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .out_valid(out_valid),
        .out_ready(out_ready), .out_p(out_p), .busy(busy), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b;
        logic [63:0] c, exp;
        int          stall;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one full operation; inputs scramble while busy so any late capture shows up in the result
    task automatic run_op(input logic [31:0] a, b, input logic [63:0] c, input int stall,
                          output logic [63:0] p);
        int          lat;
        logic [63:0] held;
        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_a = a; in_b = b; in_c = c; in_valid = 1; out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 0;
        check("in_ready_after_accept", 64'(in_ready), 64'd0);
        check("busy_after_accept", 64'(busy), 64'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            in_a = $urandom; in_b = $urandom; in_c = {$urandom, $urandom}; in_valid = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 0;
        check("latency", 64'(lat), 64'd5);
        check("pass_cnt_done", 64'(pass_cnt), 64'd4);
        held = out_p;
        for (int i = 0; i < stall; i++) begin
            in_a = $urandom; in_b = $urandom; in_c = {$urandom, $urandom}; in_valid = 1'($urandom);
            @(posedge clk); #1;
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_hold", out_p, held);
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 0;
        out_ready = 1;
        p = out_p;
        @(posedge clk); #1;
        out_ready = 0;
        check("valid_after_xfer", 64'(out_valid), 64'd0);
        check("in_ready_after_xfer", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] p;
        logic [31:0] ra, rb;
        logic [63:0] rc;
        int          n;
        vecs[0] = '{32'd3,        32'd5,        64'd7,                  64'h16,                 0};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0,                  64'hFFFFFFFE00000001,   0};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000001FFFFFFFF,   64'd0,                  0};
        vecs[3] = '{32'd0,        32'd12345,    64'hDEAD,               64'hDEAD,               1};
        vecs[4] = '{32'd1,        32'h80000000, 64'd0,                  64'h80000000,           0};
        vecs[5] = '{32'h10000,    32'h10000,    64'd0,                  64'h100000000,          2};
        vecs[6] = '{32'd7,        32'd9,        64'hFFFFFFFFFFFFFFFF,   64'h3E,                 0};
        vecs[7] = '{32'h1234,     32'h10,       64'd5,                  64'h12345,              10};

        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pass_cnt", 64'(pass_cnt), 64'd0);
        check("rst_out_p", out_p, 64'd0);
        rst_n = 1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].stall, p);
            check($sformatf("vec%0d_p", i), p, vecs[i].exp);
        end

        // reset in the middle of ACCUM
        in_a = 32'h55; in_b = 32'h77; in_c = 64'h9; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        n = 0;
        while (pass_cnt != 3'd2 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_pass2", 64'(pass_cnt), 64'd2);
        #2 rst_n = 0;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_pass_cnt", 64'(pass_cnt), 64'd0);
        check("mid_rst_out_p", out_p, 64'd0);
        @(posedge clk); #3;
        rst_n = 1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        check("no_valid_after_rst", 64'(n), 64'd0);
        run_op(32'd2, 32'd2, 64'd0, 0, p);
        check("post_rst_p", p, 64'd4);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom; rc = {$urandom, $urandom};
            run_op(ra, rb, rc, int'($urandom_range(0, 3)), p);
            check("rand_p", p, 64'(ra) * 64'(rb) + rc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
